// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: scoreboard-based issue controller between decode and EX.
// Tracks destination registers of in-flight writers and stalls decode on
// RAW/WAW hazards. It also caps the number of outstanding writers and provides
// a drain handshake for CSR/fence sequencing.
// Optional feature macro: FORWARD_EN. When it is defined, only loads claim
// scoreboard entries, because EX/MEM bypass covers all other writers.
module id_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_regwrite_i,
  input  logic                id_memread_i,
  input  logic                ex_ready_i,
  input  logic                flush_i,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                drain_req_i,
  output logic                id_stall_o,
  output logic                issue_o,
  output logic                drain_done_o,
  output logic [NUM_REGS-1:0] sb_busy_o,
  output logic [3:0]          inflight_cnt_o,
  output logic [CNT_W-1:0]    stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0]          MAX_CNT = 4'(MAX_INFLIGHT);
  localparam logic [NUM_REGS-1:0] ONE_HOT = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] sb_busy_q, sb_busy_d;
  logic [3:0]          inflight_q, inflight_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic                hazard_s;
  logic                would_set_s;
  logic                full_s;
  logic                stall_s;
  logic                issue_s;
  logic                set_s;
  logic                clr_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // Hazard, capacity and issue decisions, evaluated against the registered scoreboard only
  always_comb begin
    hazard_s = (id_use_rs1_i & sb_busy_q[id_rs1_i]) |
               (id_use_rs2_i & sb_busy_q[id_rs2_i]) |
               (id_regwrite_i & sb_busy_q[id_rd_i]);
`ifdef FORWARD_EN
    would_set_s = id_regwrite_i & id_memread_i & (id_rd_i != 5'd0);
`else
    would_set_s = id_regwrite_i & (id_rd_i != 5'd0);
`endif
    full_s  = (inflight_q == MAX_CNT) & would_set_s;
    stall_s = id_valid_i & (hazard_s | full_s | ~ex_ready_i | (state_q != ST_RUN));
    issue_s = id_valid_i & ~stall_s & ~flush_i;
    set_s   = issue_s & would_set_s;
    clr_s   = wb_valid_i & (wb_rd_i != 5'd0) & sb_busy_q[wb_rd_i];
  end

  // Next scoreboard, in-flight count and stall counter; set and clear never target the same register
  always_comb begin
    if (set_s) begin
      set_mask_s = ONE_HOT << id_rd_i;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clr_s) begin
      clr_mask_s = ONE_HOT << wb_rd_i;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    sb_busy_d = ((sb_busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT;

    case ({set_s, clr_s})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Drain sequencing: wait for all writers to retire, then hold DONE until the request drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!drain_req_i) begin
          state_d = ST_RUN;
        end else if (inflight_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!drain_req_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; reset forgets every pending writeback
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      sb_busy_q   <= {NUM_REGS{1'b0}};
      inflight_q  <= 4'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      sb_busy_q   <= sb_busy_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_stall_o     = stall_s;
  assign issue_o        = issue_s;
  assign drain_done_o   = (state_q == ST_DONE);
  assign sb_busy_o      = sb_busy_q;
  assign inflight_cnt_o = inflight_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Testbench for id_hazard_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural scoreboard model.
module tb_id_hazard_ctrl;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_ready, flush, wb_valid, drain_req;
  logic        id_stall, issue, drain_done;
  logic [31:0] sb_busy;
  logic [3:0]  inflight_cnt;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_busy [32];
  int          m_infl;
  int          m_phase;   // 0 running, 1 draining, 2 drained
  longint      m_stalls;

  id_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .ex_ready_i(ex_ready),
    .flush_i(flush), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .drain_req_i(drain_req),
    .id_stall_o(id_stall), .issue_o(issue), .drain_done_o(drain_done), .sb_busy_o(sb_busy),
    .inflight_cnt_o(inflight_cnt), .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_infl   = 0;
    m_phase  = 0;
    m_stalls = 0;
  endtask

  function automatic bit m_claims();
`ifdef FORWARD_EN
    return id_regwrite && id_memread && (id_rd != 5'd0);
`else
    return id_regwrite && (id_rd != 5'd0);
`endif
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic set_instr(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                           input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  // One clock cycle: compare every output with the model, then advance the model across the edge.
  task automatic step();
    bit          blocked, e_stall, e_issue, clr, set;
    logic [31:0] e_busy;
    int          n_phase;
    #1;
    blocked = (id_use_rs1 && m_busy[id_rs1]) || (id_use_rs2 && m_busy[id_rs2]) ||
              (id_regwrite && m_busy[id_rd]) || (m_infl == MAXI && m_claims()) ||
              !ex_ready || (m_phase != 0);
    e_stall = id_valid && blocked;
    e_issue = id_valid && !blocked && !flush;
    for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];
    check("id_stall", id_stall, e_stall);
    check("issue", issue, e_issue);
    check("drain_done", drain_done, m_phase == 2);
    check("sb_busy", sb_busy, e_busy);
    check("inflight", inflight_cnt, m_infl);
    check("stall_cycles", stall_cycles, m_stalls);
    clr = wb_valid && (wb_rd != 5'd0) && m_busy[wb_rd];
    set = e_issue && m_claims();
    n_phase = m_phase;
    if (m_phase == 0 && drain_req) n_phase = 1;
    else if (m_phase == 1 && !drain_req) n_phase = 0;
    else if (m_phase == 1 && m_infl == 0) n_phase = 2;
    else if (m_phase == 2 && !drain_req) n_phase = 0;
    @(posedge clk);
    if (clr) begin m_busy[wb_rd] = 1'b0; m_infl--; end
    if (set) begin m_busy[id_rd] = 1'b1; m_infl++; end
    if (e_stall && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    m_phase = n_phase;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ex_ready = 1; drain_req = 0; rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    #1;
    check("rst_busy", sb_busy, 32'd0);
    check("rst_infl", inflight_cnt, 4'd0);
    check("rst_stalls", stall_cycles, 32'd0);
    check("rst_done", drain_done, 1'b0);

    // add x10,x11,x12 issues and claims x10
    set_instr(1, 11, 12, 1, 1, 10, 1, 1);
    #1 check("t1_issue", issue, 1'b1);
    step();
    idle();
    check("t1_busy10", sb_busy[10], 1'b1);
    check("t1_infl", inflight_cnt, 4'd1);

    // dependent add x5,x10,x0 waits until the cycle after writeback of x10
    set_instr(1, 10, 0, 1, 1, 5, 1, 0);
    repeat (3) begin
      #1 check("t2_stall", id_stall, 1'b1);
      step();
    end
    wb_valid = 1; wb_rd = 10;
    #1 check("t2_stall_wb", id_stall, 1'b1);
    step();
    wb_valid = 0;
    #1 check("t2_unstall", id_stall, 1'b0);
    check("t2_issue", issue, 1'b1);
    step();
    idle();
    wb_valid = 1; wb_rd = 5;
    step();
    idle();

`ifdef FORWARD_EN
    // load-use stalls; ALU result is bypassed
    pulse_reset();
    set_instr(1, 0, 0, 0, 0, 10, 1, 1);
    step();
    set_instr(1, 10, 0, 1, 0, 5, 1, 0);
    #1 check("f_ld_stall", id_stall, 1'b1);
    step();
    wb_valid = 1; wb_rd = 10;
    step();
    wb_valid = 0;
    #1 check("f_ld_release", issue, 1'b1);
    step();
    set_instr(1, 0, 0, 0, 0, 10, 1, 0);
    step();
    set_instr(1, 10, 0, 1, 0, 5, 1, 0);
    #1 check("f_alu_nostall", id_stall, 1'b0);
    step();
    idle();
`endif

    // in-flight cap: four writers fill the table, the fifth waits for a retirement
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      set_instr(1, 0, 0, 0, 0, i, 1, 1);
      step();
    end
    set_instr(1, 0, 0, 0, 0, 6, 1, 1);
    #1 check("full_stall", id_stall, 1'b1);
    step();
    wb_valid = 1; wb_rd = 1;
    #1 check("full_stall_wb", id_stall, 1'b1);
    step();
    wb_valid = 0;
    #1 check("full_issue", issue, 1'b1);
    step();
    idle();

    // drain with two writers outstanding
    pulse_reset();
    set_instr(1, 0, 0, 0, 0, 1, 1, 1); step();
    set_instr(1, 0, 0, 0, 0, 2, 1, 1); step();
    idle();
    drain_req = 1;
    step();
    set_instr(1, 0, 0, 0, 0, 7, 1, 1);
    #1 check("drain_block", id_stall, 1'b1);
    step();
    wb_valid = 1; wb_rd = 1; step();
    wb_rd = 2; step();
    wb_valid = 0;
    #1 check("drain_infl0", inflight_cnt, 4'd0);
    check("drain_not_yet", drain_done, 1'b0);
    step();
    #1 check("drain_done", drain_done, 1'b1);
    step();
    drain_req = 0;
    step();
    #1 check("drain_resume", issue, 1'b1);
    step();
    idle();

    // randomized traffic over a small register window to provoke hazards
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      ex_ready = $urandom_range(0, 6) != 0;
      flush    = $urandom_range(0, 9) == 0;
      wb_valid = $urandom_range(0, 4) < 2;
      wb_rd    = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      step();
    end
    idle();
    drain_req = 0; ex_ready = 1;
    step();

    // asynchronous reset in the middle of a long stall
    pulse_reset();
    set_instr(1, 0, 0, 0, 0, 3, 1, 1);
    step();
    ex_ready = 0;
    set_instr(1, 0, 0, 0, 0, 8, 1, 1);
    repeat (10) step();
    check("pre_rst_stalls", stall_cycles, 32'd10);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", sb_busy, 32'd0);
    check("mid_rst_infl", inflight_cnt, 4'd0);
    check("mid_rst_stalls", stall_cycles, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
